// File: rtl/fire_alarm_pkg.sv
// rtl/fire_alarm_pkg.sv - shared state encodings, countdown command codes and reload value
package fire_alarm_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    VERIFY    = 3'd1,
    COUNTDOWN = 3'd2,
    ALARM     = 3'd3,
    SILENCED  = 3'd4
  } state_t;

  localparam logic [1:0] SIG_LOAD  = 2'b00;
  localparam logic [1:0] SIG_COUNT = 2'b01;
  localparam logic [1:0] SIG_HOLD  = 2'b10;

  localparam int COUNT_RELOAD = 10;

endpackage

// File: rtl/countdown_10s.sv
// rtl/countdown_10s.sv - reloadable down counter driven by the alarm controller's sig command
module countdown_10s
  import fire_alarm_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [1:0]         i_sig,
  output logic [COUNT_W-1:0] o_count
);

  logic [COUNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= COUNT_W'(COUNT_RELOAD);
    end else begin
      case (i_sig)
        SIG_LOAD:  r_count <= COUNT_W'(COUNT_RELOAD);
        SIG_COUNT: if (r_count != '0) r_count <= r_count - COUNT_W'(1);
        default:   r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for one asynchronous level input
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fire_alarm_ctrl.sv
// rtl/fire_alarm_ctrl.sv - smoke/heat alarm sequencer that drives countdown_10s and the sounders
module fire_alarm_ctrl
  import fire_alarm_pkg::*;
#(
  parameter int TICK_DIV     = 50_000_000,
  parameter int DEBOUNCE_CYC = 1_000,
  parameter int COUNT_W      = 8
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_smoke,
  input  logic               i_heat,
  input  logic               i_ack,
  input  logic               i_clear,
  input  logic [COUNT_W-1:0] i_count,
  output logic [1:0]         o_sig,
  output logic               o_buzzer,
  output logic               o_siren,
  output logic               o_sprinkler,
  output logic [2:0]         o_state
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);

  logic w_smoke_s, w_heat_s, w_ack_s, w_clear_s;
  logic w_clear_ok, w_heat_rise, w_tick, w_deb_done;
  state_t r_state, w_next;
  logic r_heat_d;
  logic [PRE_W-1:0] r_pre;
  logic [DEB_W-1:0] r_deb;
  logic [1:0] r_sig;
  logic r_buzzer, r_siren, r_sprinkler;
  logic [2:0] r_state_o;

  sync_2ff u_sync_smoke (.i_clk(i_clk), .i_rst_n(i_reset_n), .i_d(i_smoke), .o_q(w_smoke_s));
  sync_2ff u_sync_heat  (.i_clk(i_clk), .i_rst_n(i_reset_n), .i_d(i_heat),  .o_q(w_heat_s));
  sync_2ff u_sync_ack   (.i_clk(i_clk), .i_rst_n(i_reset_n), .i_d(i_ack),   .o_q(w_ack_s));
  sync_2ff u_sync_clear (.i_clk(i_clk), .i_rst_n(i_reset_n), .i_d(i_clear), .o_q(w_clear_s));

  // Maintenance clear only counts once both sensors have gone quiet.
  assign w_clear_ok  = w_clear_s && !w_smoke_s && !w_heat_s;
  assign w_heat_rise = w_heat_s && !r_heat_d;
  assign w_tick      = (r_pre == PRE_W'(TICK_DIV - 1));
  assign w_deb_done  = (r_deb == DEB_W'(DEBOUNCE_CYC - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_heat_s)       w_next = ALARM;
        else if (w_smoke_s) w_next = VERIFY;
      end
      VERIFY: begin
        if (w_heat_s)        w_next = ALARM;
        else if (!w_smoke_s) w_next = IDLE;
        else if (w_deb_done) w_next = COUNTDOWN;
      end
      COUNTDOWN: begin
        if (w_heat_s)            w_next = ALARM;
        else if (i_count == '0)  w_next = ALARM;
        else if (w_ack_s)        w_next = IDLE;
      end
      ALARM: begin
        if (w_clear_ok)   w_next = IDLE;
        else if (w_ack_s) w_next = SILENCED;
      end
      SILENCED: begin
        if (w_clear_ok)       w_next = IDLE;
        else if (w_heat_rise) w_next = ALARM;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= IDLE;
      r_heat_d <= 1'b0;
      r_pre    <= '0;
      r_deb    <= '0;
    end else begin
      r_state  <= w_next;
      r_heat_d <= w_heat_s;
      // Both counters sit at zero outside their state, so entry always starts clean.
      if (r_state == COUNTDOWN) r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
      else                      r_pre <= '0;
      if (r_state == VERIFY && w_smoke_s) r_deb <= r_deb + DEB_W'(1);
      else                                r_deb <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sig       <= SIG_LOAD;
      r_buzzer    <= 1'b0;
      r_siren     <= 1'b0;
      r_sprinkler <= 1'b0;
      r_state_o   <= 3'd0;
    end else begin
      r_sig       <= SIG_LOAD;
      r_buzzer    <= 1'b0;
      r_siren     <= 1'b0;
      r_sprinkler <= 1'b0;
      r_state_o   <= r_state;
      case (r_state)
        COUNTDOWN: begin
          r_buzzer <= 1'b1;
          r_sig    <= w_tick ? SIG_COUNT : SIG_HOLD;
        end
        ALARM: begin
          r_siren     <= 1'b1;
          r_sprinkler <= 1'b1;
        end
        SILENCED: r_sprinkler <= 1'b1;
        default: ;
      endcase
    end
  end

  assign o_sig       = r_sig;
  assign o_buzzer    = r_buzzer;
  assign o_siren     = r_siren;
  assign o_sprinkler = r_sprinkler;
  assign o_state     = r_state_o;

endmodule

// File: tb/tb_fire_alarm_ctrl.sv
// tb/tb_fire_alarm_ctrl.sv - directed and randomized checks of fire_alarm_ctrl with a real countdown_10s
module tb_fire_alarm_ctrl;
  import fire_alarm_pkg::*;

  localparam int TICK = 4;
  localparam int DEB  = 3;
  localparam int CW   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic smoke = 1'b0, heat = 1'b0, ack = 1'b0, clr = 1'b0;
  logic [CW-1:0] count;
  logic [1:0] sig;
  logic buzzer, siren, sprinkler;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  int cyc = 0, pulses = 0, last_pulse = -1, gap_err = 0, count_min = 255;
  bit seen_buzz = 0;
  bit [7:0] seen_states = '0;

  always #5 clk = ~clk;

  fire_alarm_ctrl #(.TICK_DIV(TICK), .DEBOUNCE_CYC(DEB), .COUNT_W(CW)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_smoke(smoke), .i_heat(heat), .i_ack(ack),
    .i_clear(clr), .i_count(count), .o_sig(sig), .o_buzzer(buzzer), .o_siren(siren),
    .o_sprinkler(sprinkler), .o_state(state)
  );

  countdown_10s #(.COUNT_W(CW)) u_cd (
    .i_clk(clk), .i_reset(~rst_n), .i_sig(sig), .o_count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_flags();
    pulses = 0; last_pulse = -1; gap_err = 0; count_min = 255;
    seen_buzz = 0; seen_states = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (sig == SIG_COUNT) begin
      if (last_pulse >= 0 && cyc - last_pulse != TICK) gap_err++;
      last_pulse = cyc;
      pulses++;
    end
    if (buzzer) seen_buzz = 1;
    seen_states[state] = 1'b1;
    if (int'(count) < count_min) count_min = int'(count);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_count(input logic [CW-1:0] k, input int budget, input string tag);
    int i = 0;
    while (count !== k && i < budget) begin tick(); i++; end
    chk(tag, 32'(count), 32'(k));
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int i = 0;
    while (state !== s && i < budget) begin tick(); i++; end
    chk(tag, 32'(state), 32'(s));
  endtask

  task automatic clear_to_idle();
    smoke = 0; heat = 0;
    run(4);
    clr = 1; run(3); clr = 0;
    run(4);
  endtask

  initial begin
    int t_start, w, k;
    bit exp_cd;

    // Reset state
    run(3);
    chk("rst_state", 32'(state), 32'(IDLE));
    chk("rst_sig", 32'(sig), 32'(SIG_LOAD));
    chk("rst_buzzer", 32'(buzzer), 0);
    chk("rst_siren", 32'(siren), 0);
    chk("rst_sprinkler", 32'(sprinkler), 0);
    chk("rst_count", 32'(count), 10);
    rst_n = 1;
    run(3);
    chk("idle_after_rst", 32'(state), 32'(IDLE));

    // Short smoke pulse: VERIFY then back to IDLE, countdown untouched
    clr_flags();
    smoke = 1; run(2); smoke = 0;
    run(10);
    chk("short_seen_verify", 32'(seen_states[VERIFY]), 1);
    chk("short_no_countdown", 32'(seen_states[COUNTDOWN]), 0);
    chk("short_no_buzz", 32'(seen_buzz), 0);
    chk("short_count_min", 32'(count_min), 10);
    chk("short_end_idle", 32'(state), 32'(IDLE));

    // Smoke held: full countdown into ALARM
    clr_flags();
    smoke = 1;
    wait_state(COUNTDOWN, 50, "full_enter_countdown");
    t_start = cyc;
    chk("full_buzzer_on", 32'(buzzer), 1);
    begin
      int i = 0;
      while (siren !== 1'b1 && i < 100) begin tick(); i++; end
    end
    chk("full_siren", 32'(siren), 1);
    // o_state and siren share one register stage, so only the countdown itself separates them
    chk("full_latency", 32'(cyc - t_start), 32'(10 * TICK + 2));
    chk("full_pulses", 32'(pulses), 10);
    chk("full_gap_err", 32'(gap_err), 0);
    chk("full_count_min", 32'(count_min), 0);
    chk("full_sprinkler", 32'(sprinkler), 1);
    chk("full_state", 32'(state), 32'(ALARM));
    clear_to_idle();
    chk("full_cleared", 32'(state), 32'(IDLE));
    chk("full_sprinkler_off", 32'(sprinkler), 0);

    // Ack at count 6 cancels; smoke dropping earlier does not
    clr_flags();
    smoke = 1;
    wait_count(8, 200, "ack6_reach8");
    smoke = 0;
    wait_count(6, 100, "ack6_reach6");
    chk("ack6_still_countdown", 32'(state), 32'(COUNTDOWN));
    ack = 1; tick(); ack = 0;
    run(8);
    chk("ack6_idle", 32'(state), 32'(IDLE));
    chk("ack6_reload", 32'(count), 10);
    chk("ack6_buzzer", 32'(buzzer), 0);
    chk("ack6_sig", 32'(sig), 32'(SIG_LOAD));

    // Ack landing in the same synchronized cycle as count==0 loses to ALARM
    clr_flags();
    smoke = 1;
    wait_count(1, 200, "race_reach1");
    run(2);
    chk("race_still1", 32'(count), 1);
    ack = 1; tick(); ack = 0;
    clr_flags();
    run(6);
    chk("race_state", 32'(state), 32'(ALARM));
    chk("race_siren", 32'(siren), 1);
    chk("race_never_idle", 32'(seen_states[IDLE]), 0);
    clear_to_idle();
    chk("race_cleared", 32'(state), 32'(IDLE));

    // Heat in IDLE goes straight to ALARM; clear ignored while heat is up
    clr_flags();
    heat = 1; run(6);
    chk("heat_alarm", 32'(state), 32'(ALARM));
    chk("heat_siren", 32'(siren), 1);
    chk("heat_count_min", 32'(count_min), 10);
    chk("heat_no_buzz", 32'(seen_buzz), 0);
    clr = 1; run(4); clr = 0; run(3);
    chk("heat_clear_ignored", 32'(state), 32'(ALARM));
    clear_to_idle();
    chk("heat_cleared", 32'(state), 32'(IDLE));

    // ALARM -> SILENCED by ack, re-armed by a new heat edge, then async reset
    heat = 1; run(5); heat = 0; run(4);
    ack = 1; tick(); ack = 0; run(4);
    chk("sil_state", 32'(state), 32'(SILENCED));
    chk("sil_siren", 32'(siren), 0);
    chk("sil_sprinkler", 32'(sprinkler), 1);
    heat = 1; run(5);
    chk("rearm_state", 32'(state), 32'(ALARM));
    chk("rearm_siren", 32'(siren), 1);
    rst_n = 0;
    #1;
    chk("async_state", 32'(state), 32'(IDLE));
    chk("async_siren", 32'(siren), 0);
    chk("async_sprinkler", 32'(sprinkler), 0);
    chk("async_sig", 32'(sig), 32'(SIG_LOAD));
    heat = 0;
    run(3);
    rst_n = 1;
    run(4);
    chk("post_rst_idle", 32'(state), 32'(IDLE));
    chk("post_rst_count", 32'(count), 10);

    // Random smoke widths: countdown starts only if smoke_s lasts one IDLE cycle plus DEB VERIFY cycles
    for (int t = 0; t < 8; t++) begin
      w = $urandom_range(1, 7);
      exp_cd = (w >= DEB + 1);
      clr_flags();
      smoke = 1; run(w); smoke = 0;
      run(4);
      chk("rnd_verify_seen", 32'(seen_states[VERIFY]), 1);
      chk("rnd_state", 32'(state), exp_cd ? 32'(COUNTDOWN) : 32'(IDLE));
      chk("rnd_buzz", 32'(buzzer), 32'(exp_cd));
      if (exp_cd) begin
        k = $urandom_range(1, 8);
        wait_count(CW'(k), 200, "rnd_reach_k");
        chk("rnd_pulses", 32'(pulses), 32'(10 - k));
        ack = 1; tick(); ack = 0;
        run(8);
        chk("rnd_cancel_idle", 32'(state), 32'(IDLE));
        chk("rnd_cancel_count", 32'(count), 10);
      end else begin
        chk("rnd_count_min", 32'(count_min), 10);
      end
      run(4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
